// File: rtl/prog_mem.sv
// Dual-read program/data memory: byte-enabled write port, 1-cycle data read port and
// an instruction fetch port with stall, all sharing one word array with write-first bypass.
module prog_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4096
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                wr_en_i,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    input  logic [DATA_W-1:0]   wr_data_i,
    input  logic [DATA_W/8-1:0] wr_be_i,
    input  logic                rd_req_i,
    input  logic [ADDR_W-1:0]   rd_addr_i,
    output logic [DATA_W-1:0]   rd_data_o,
    output logic                rd_valid_o,
    output logic                rd_err_o,
    input  logic [ADDR_W-1:0]   pc_addr_i,
    input  logic                pc_hold_i,
    output logic [DATA_W-1:0]   instr_o,
    output logic                instr_err_o,
    output logic [15:0]         wr_cnt_o
);
    localparam int NB  = DATA_W / 8;
    localparam int OFF = $clog2(NB);
    localparam int IW  = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_word, rd_word, pc_word;
    logic              wr_in, rd_in, pc_in, wr_hit;
    logic [IW-1:0]     wr_idx, rd_idx, pc_idx;
    logic [DATA_W-1:0] wr_old, wr_merged;
    logic [DATA_W-1:0] rd_data_d, instr_d;

    logic [DATA_W-1:0] rd_data_q, instr_q;
    logic              rd_valid_q, rd_err_q, instr_err_q;
    logic [15:0]       wr_cnt_q;

    // Low byte-offset bits are discarded; anything at or beyond DEPTH is out of range.
    assign wr_word = wr_addr_i >> OFF;
    assign rd_word = rd_addr_i >> OFF;
    assign pc_word = pc_addr_i >> OFF;
    assign wr_in   = wr_word < DEPTH_A;
    assign rd_in   = rd_word < DEPTH_A;
    assign pc_in   = pc_word < DEPTH_A;
    assign wr_idx  = wr_word[IW-1:0];
    assign rd_idx  = rd_word[IW-1:0];
    assign pc_idx  = pc_word[IW-1:0];
    assign wr_hit  = wr_en_i && wr_in;
    assign wr_old  = mem_q[wr_idx];

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign wr_merged[gi*8 +: 8] = wr_be_i[gi] ? wr_data_i[gi*8 +: 8] : wr_old[gi*8 +: 8];
        end
    endgenerate

    // Same-edge readers see the merged word the write is about to store.
    always_comb begin
        rd_data_d = mem_q[rd_idx];
        instr_d   = mem_q[pc_idx];
        if (wr_hit && (wr_idx == rd_idx)) begin
            rd_data_d = wr_merged;
        end
        if (wr_hit && (wr_idx == pc_idx)) begin
            instr_d = wr_merged;
        end
    end

    // Storage is never reset; writes are ignored while reset is held.
    always_ff @(posedge sys_clk) begin
        if (sys_rst_n && wr_hit) begin
            for (int k = 0; k < NB; k++) begin
                if (wr_be_i[k]) begin
                    mem_q[wr_idx][k*8 +: 8] <= wr_data_i[k*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_err_q    <= 1'b0;
            instr_q     <= '0;
            instr_err_q <= 1'b0;
            wr_cnt_q    <= '0;
        end else begin
            rd_valid_q <= rd_req_i;
            rd_err_q   <= rd_req_i && !rd_in;
            if (rd_req_i) begin
                rd_data_q <= rd_in ? rd_data_d : '0;
            end
            if (!pc_hold_i) begin
                instr_q     <= pc_in ? instr_d : '0;
                instr_err_q <= !pc_in;
            end
            if (wr_hit && (wr_cnt_q != 16'hFFFF)) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
        end
    end

    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign rd_err_o    = rd_err_q;
    assign instr_o     = instr_q;
    assign instr_err_o = instr_err_q;
    assign wr_cnt_o    = wr_cnt_q;
endmodule
